// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM state encoding and the READ ID byte selector.
package spi_flash_responder_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_ID     = 3'd4,
    ST_STAT   = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  // Byte idx of the 24-bit JEDEC ID, MSB first; anything past the third byte reads 0x00.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      2'd2:    return id[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the parallel preload port of the flash responder.
interface spi_flash_responder_if #(
  parameter int ADDR_W = 12
);
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              busy;
  logic              cmd_err;

  // The CPU side / bench drives the pins and the load port.
  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, load_en, load_addr, load_data,
    input  spi_miso, spi_miso_oe, busy, cmd_err
  );

  // The responder.
  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, load_en, load_addr, load_data,
    output spi_miso, spi_miso_oe, busy, cmd_err
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronizes CS/SCLK/MOSI into clk and produces edge strobes.
// MOSI goes through the same depth as SCLK so a rise strobe sees the matching data bit.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cs_n,
  input  logic i_sclk,
  input  logic i_mosi,
  output logic o_cs_n,
  output logic o_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_fall,
  output logic o_cs_rise
);

  logic [SYNC_STAGES-1:0] r_cs_chain;
  logic [SYNC_STAGES-1:0] r_sclk_chain;
  logic [SYNC_STAGES-1:0] r_mosi_chain;
  logic [SYNC_STAGES-1:0] r_valid;
  logic                   r_cs_prev;
  logic                   r_sclk_prev;
  logic                   r_armed;
  logic                   w_cs;
  logic                   w_sclk;

  assign w_cs   = r_cs_chain[SYNC_STAGES-1];
  assign w_sclk = r_sclk_chain[SYNC_STAGES-1];

  // Flop chains, previous-value registers, and the arm flag. r_valid marks when the
  // chain end holds a real post-reset sample; CS must be seen high after that before
  // a falling edge is accepted, so a CS held low through reset is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_chain   <= '1;
      r_sclk_chain <= '0;
      r_mosi_chain <= '0;
      r_valid      <= '0;
      r_cs_prev    <= 1'b1;
      r_sclk_prev  <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_cs_chain   <= {r_cs_chain[SYNC_STAGES-2:0], i_cs_n};
      r_sclk_chain <= {r_sclk_chain[SYNC_STAGES-2:0], i_sclk};
      r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], i_mosi};
      r_valid      <= {r_valid[SYNC_STAGES-2:0], 1'b1};
      r_cs_prev    <= w_cs;
      r_sclk_prev  <= w_sclk;
      if (r_valid[SYNC_STAGES-1] && w_cs) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_cs_n      = w_cs;
  assign o_mosi      = r_mosi_chain[SYNC_STAGES-1];
  assign o_sclk_rise = w_sclk & ~r_sclk_prev;
  assign o_sclk_fall = ~w_sclk & r_sclk_prev;
  assign o_cs_fall   = r_armed & r_cs_prev & ~w_cs;
  assign o_cs_rise   = w_cs & ~r_cs_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash ROM emulator: READ (0x03, continuous), READ ID (0x9F), READ STATUS (0x05),
// backed by a preloadable byte array. Mode 0, pins oversampled in the clk domain.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4013
) (
  input logic                        clk,
  input logic                        rst_n,
  spi_flash_responder_if.slave       spi_bus
);

  logic              w_cs_n;
  logic              w_mosi;
  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_cs_fall;
  logic              w_cs_rise;
  logic [ADDR_W-1:0] w_shift_next;
  logic [7:0]        w_load_byte;

  state_t            r_state;
  logic [4:0]        r_bit_cnt;
  logic [ADDR_W-2:0] r_shift;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_tx_cnt;
  logic [7:0]        r_tx;
  logic [1:0]        r_id_idx;
  logic              r_oe;
  logic              r_busy;
  logic              r_cmd_err;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cs_n      (spi_bus.spi_cs_n),
    .i_sclk      (spi_bus.spi_sclk),
    .i_mosi      (spi_bus.spi_mosi),
    .o_cs_n      (w_cs_n),
    .o_mosi      (w_mosi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise)
  );

  // Only the low ADDR_W bits of the 24-bit address survive the shift; the opcode uses the low 8.
  assign w_shift_next = {r_shift, w_mosi};

  // Array preload and continuously running registered read of the current address.
  always_ff @(posedge clk) begin
    if (spi_bus.load_en) begin
      r_mem[spi_bus.load_addr] <= spi_bus.load_data;
    end
    r_rd_data <= r_mem[r_addr];
  end

  // Next byte to present on a response-byte boundary, by phase.
  always_comb begin
    w_load_byte = 8'h00;
    case (r_state)
      ST_DATA: w_load_byte = r_rd_data;
      ST_ID:   w_load_byte = id_byte(JEDEC_ID, r_id_idx);
      default: w_load_byte = 8'h00;
    endcase
  end

  // Command FSM: shift opcode/address on SCLK rises, shift response out on SCLK falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_tx_cnt  <= '0;
      r_tx      <= '0;
      r_id_idx  <= '0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      r_busy    <= ~w_cs_n;
      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        r_oe    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_shift   <= w_shift_next[ADDR_W-2:0];
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
                r_id_idx  <= '0;
                case (w_shift_next[7:0])
                  OP_READ: r_state <= ST_ADDR;
                  OP_RDID: r_state <= ST_ID;
                  OP_RDSR: r_state <= ST_STAT;
                  default: begin
                    r_state   <= ST_IGNORE;
                    r_cmd_err <= 1'b1;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (w_sclk_rise) begin
              r_shift   <= w_shift_next[ADDR_W-2:0];
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd23) begin
                r_addr   <= w_shift_next;
                r_tx_cnt <= '0;
                r_state  <= ST_DATA;
              end
            end
          end
          ST_DATA, ST_ID, ST_STAT: begin
            if (w_sclk_fall) begin
              r_tx_cnt <= r_tx_cnt + 3'd1;
              if (r_tx_cnt == 3'd0) begin
                r_oe <= 1'b1;
                r_tx <= w_load_byte;
                if (r_state == ST_DATA) begin
                  r_addr <= r_addr + 1'b1;
                end
                if (r_state == ST_ID && r_id_idx != 2'd3) begin
                  r_id_idx <= r_id_idx + 2'd1;
                end
              end else begin
                r_tx <= {r_tx[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_bus.spi_miso    = r_oe & r_tx[7];
  assign spi_bus.spi_miso_oe = r_oe;
  assign spi_bus.busy        = r_busy;
  assign spi_bus.cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed SPI transactions, expected MISO bytes
// queued by the stimulus and checked by an independent MISO monitor.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic clk;
  logic rst_n;

  spi_flash_responder_if #(.ADDR_W(12)) bus ();

  spi_flash_responder #(
    .ADDR_W      (12),
    .SYNC_STAGES (2),
    .JEDEC_ID    (24'hEF4013)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi_bus (bus.slave)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         err_cnt  = 0;
  int         oe_cnt   = 0;
  int         miso_bad = 0;
  int         mon_cnt  = 0;
  logic [7:0] mon_byte = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
      $display("check %s: got %0h exp %0h ok", name, actual, expected);
    end else begin
      $display("FAIL %s: got %0h exp %0h", name, actual, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    wait_clk(HALF);
    bus.spi_sclk = 1'b1;
    wait_clk(HALF);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    wait_clk(HALF);
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    wait_clk(1);
    bus.load_en   = 1'b0;
  endtask

  task automatic read_cmd(input logic [23:0] a, input int nbytes);
    spi_byte(8'h03);
    spi_byte(a[23:16]);
    spi_byte(a[15:8]);
    spi_byte(a[7:0]);
    for (int i = 0; i < nbytes; i++) spi_byte(8'h00);
  endtask

  // Monitor: acts as the SPI initiator's receiver, sampling MISO on each SCLK rise
  // while the output is enabled; each completed byte is checked against the queue.
  initial begin
    forever begin
      @(posedge bus.spi_sclk or posedge bus.spi_cs_n);
      if (bus.spi_cs_n) begin
        mon_cnt = 0;
      end else if (bus.spi_miso_oe) begin
        mon_byte = {mon_byte[6:0], bus.spi_miso};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mon_cnt = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL miso_byte: got %02h exp none (unexpected byte)", mon_byte);
          end else begin
            check("miso_byte", int'(mon_byte), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // Per-cycle observers for cmd_err pulses, drive-enable activity and MISO-when-off.
  always @(negedge clk) begin
    if (bus.cmd_err) err_cnt++;
    if (bus.spi_miso_oe) oe_cnt++;
    if (!bus.spi_miso_oe && bus.spi_miso) miso_bad++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.spi_cs_n  = 1'b1;
    bus.spi_sclk  = 1'b0;
    bus.spi_mosi  = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    wait_clk(5);
    check("rst_miso", int'(bus.spi_miso), 0);
    check("rst_oe", int'(bus.spi_miso_oe), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cmd_err", int'(bus.cmd_err), 0);
    rst_n = 1'b1;
    wait_clk(5);

    load(12'h000, 8'h15);
    load(12'h001, 8'h2A);
    load(12'hFFF, 8'h3F);
    load(12'hF05, 8'h2C);

    // Plain read from 0, two bytes.
    exp_q.push_back(8'h15);
    exp_q.push_back(8'h2A);
    cs_low();
    check("busy_active", int'(bus.busy), 1);
    read_cmd(24'h000000, 2);
    check("oe_data_phase", int'(bus.spi_miso_oe), 1);
    cs_high();
    check("oe_after_cs", int'(bus.spi_miso_oe), 0);
    check("busy_after_cs", int'(bus.busy), 0);

    // Wrap from the top of the array.
    load(12'h000, 8'h01);
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h01);
    cs_low();
    read_cmd(24'h000FFF, 2);
    cs_high();

    // Upper address bits ignored.
    exp_q.push_back(8'h2C);
    cs_low();
    read_cmd(24'h001F05, 1);
    cs_high();

    // READ ID then READ STATUS.
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h00);
    cs_low();
    spi_byte(8'h9F);
    for (int i = 0; i < 4; i++) spi_byte(8'h00);
    cs_high();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    cs_low();
    spi_byte(8'h05);
    spi_byte(8'h00);
    spi_byte(8'h00);
    cs_high();

    // Unsupported opcode.
    err_cnt = 0;
    oe_cnt  = 0;
    cs_low();
    spi_byte(8'hAB);
    spi_byte(8'h00);
    spi_byte(8'h00);
    check("bad_op_cmd_err_cycles", err_cnt, 1);
    check("bad_op_oe_cycles", oe_cnt, 0);
    check("bad_op_busy", int'(bus.busy), 1);
    cs_high();
    check("bad_op_busy_released", int'(bus.busy), 0);

    // Abort mid-address, then a full read of 0x001.
    cs_low();
    spi_byte(8'h03);
    for (int i = 0; i < 10; i++) spi_bit(1'b1);
    cs_high();
    exp_q.push_back(8'h2A);
    cs_low();
    read_cmd(24'h000001, 1);
    cs_high();

    // Reset with CS already low: ignored until CS toggles.
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
    rst_n = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    oe_cnt = 0;
    wait_clk(HALF);
    read_cmd(24'h000001, 1);
    check("rst_cs_low_oe_cycles", oe_cnt, 0);
    cs_high();
    exp_q.push_back(8'h2A);
    cs_low();
    read_cmd(24'h000001, 1);
    cs_high();

    wait_clk(10);
    check("queue_drained", exp_q.size(), 0);
    check("total_cmd_err_cycles", err_cnt, 1);
    check("miso_when_oe_low", miso_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI-flash responder that emulates the serial ROM our 6-bit core boots and executes from. It answers the standard READ (0x03) sequence, continuous sequential reads with CS held low, READ ID (0x9F) and READ STATUS (0x05) from an internal byte array. The array is preloaded through a parallel load port. The block sits on the far side of the CPU's CS/SCLK/MOSI/MISO pins, either as an on-chip ROM emulator or as a synthesizable bench model. It oversamples the SPI pins in its own `clk` domain.

## Interface
- `ADDR_W`, 12: array depth is 2^ADDR_W bytes; the low ADDR_W address bits are used.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_cs_n`, `spi_sclk` and `spi_mosi`.
- `JEDEC_ID`, 24'hEF4013: returned MSB-first by 0x9F.
- `clk`  in  1  block clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `spi_cs_n`  in  1  chip select, active low, asynchronous to `clk`.
- `spi_sclk`  in  1  SPI clock, mode 0, asynchronous.
- `spi_mosi`  in  1  serial data from the initiator.
- `spi_miso`  out  1  serial data to the initiator.
- `spi_miso_oe`  out  1  MISO drive enable; 1 only during response phases.
- `load_en`  in  1  write `load_data` to `load_addr` this cycle.
- `load_addr`  in  ADDR_W  load address.
- `load_data`  in  8  load byte.
- `busy`  out  1  synchronized CS is asserted.
- `cmd_err`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- Mode 0: MOSI is sampled on the SCLK rising edge. MISO changes on the SCLK falling edge. All bytes are MSB first.
- Edges are detected from the synchronized SCLK. MOSI is delayed by the same number of stages so both stay aligned.
- States:
  - IDLE → CMD on synchronized CS falling.
  - CMD: shift 8 bits, then decode:
    - 0x03 → ADDR.
    - 0x9F → ID.
    - 0x05 → STAT.
    - Any other opcode → IGNORE and pulse `cmd_err`.
  - ADDR: shift 24 bits into `addr`, then → DATA.
  - DATA, ID and STAT run until CS deasserts.
  - IGNORE: no response until CS deasserts.
- CS deassert (synchronized rising) from any state → IDLE. This aborts partial bytes with no side effects.
- DATA:
  - A registered array read of `addr` runs continuously.
  - On the falling edge after the last ADDR bit, and after every 8th data bit, the output shift register loads `mem[addr]` and `addr` increments.
  - The increment wraps from 2^ADDR_W−1 to 0.
  - MISO shows bit 7 of the loaded byte at that edge. Each following falling edge shifts left.
- ID: outputs JEDEC_ID[23:16], [15:8], [7:0], then 0x00 while clocked.
- STAT: outputs 0x00 repeatedly (never busy, never write-enabled).
- Address bits [23:ADDR_W] are ignored.
- `spi_miso_oe` is 1 from the first response load until leaving the state. `spi_miso` is 0 whenever `spi_miso_oe` is 0.
- Load port:
  - Writes take effect at the next `clk` edge and are accepted in any state.
  - A byte loaded into the shift register reflects the array contents at the cycle it is loaded.
- Reset:
  - `spi_miso`=0, `spi_miso_oe`=0, `busy`=0, `cmd_err`=0, state=IDLE.
  - Synchronizers clear to CS high and SCLK low.
  - The array is not cleared.
- After reset, a CS already low is ignored. The next command starts only after CS is seen high and then falls.

## Timing
- SCLK high and low phases must each be ≥ SYNC_STAGES+2 `clk` periods. The CS setup and hold to the first and last SCLK edge must also be ≥ SYNC_STAGES+2.
- Response latency: MISO updates SYNC_STAGES+1 `clk` after the SCLK falling edge at the pin. This must complete before the next rising edge.
- `busy` follows the pin CS with SYNC_STAGES+1 cycle latency.
- `cmd_err` is asserted SYNC_STAGES+1 cycles after the 8th command rising edge, for exactly 1 cycle.
- Back-to-back transactions need CS high for at least SYNC_STAGES+2 cycles.

## Structure
- The shared package holds:
  - Opcode constants `OP_READ`=8'h03, `OP_RDID`=8'h9F, `OP_RDSR`=8'h05.
  - The state enum IDLE/CMD/ADDR/DATA/ID/STAT/IGNORE.
- Sub-module `spi_pin_sync`: a SYNC_STAGES flop chain per pin, plus SCLK rise/fall and CS fall/rise strobes. It is instantiated once.
- The array is an inferred 2^ADDR_W×8 memory with a registered read port.

## Test plan
- Preload mem[0x000]=0x15 and mem[0x001]=0x2A. Send 03 00 00 00, then clock 16 bits → MISO returns 0x15, 0x2A and `spi_miso_oe`=1 throughout the data phase.
- Preload mem[0xFFF]=0x3F and mem[0x000]=0x01. Read from 03 00 0F FF for 16 bits → 0x3F, 0x01 (wrap).
- Send 03 00 1F 05 → returns mem[0xF05] (upper bits ignored).
- Send 9F, then clock 32 bits → EF 40 13 00. Send 05 → 00.
- Send AB → `cmd_err` pulses 1 cycle, `spi_miso_oe` stays 0, `busy`=1 until CS rises.
- Two abort/reset cases:
  - Raise CS after 10 address bits, then issue a full 03 00 00 01 → mem[0x001] is returned.
  - Assert `rst_n`=0 with CS low, release, keep CS low and clock 03... → no response until CS toggles high then low.
